// File: rtl/j68_pkg.sv
// Shared definitions for the J68 microcode loader: FSM states, default sync
// marker and the 16-bit checksum step.
package j68_pkg;

    typedef enum logic [3:0] {
        ST_SYNC,
        ST_CNT_LO,
        ST_CNT_HI,
        ST_W0,
        ST_W1,
        ST_W2,
        ST_CK_LO,
        ST_CK_HI,
        ST_VERIFY,
        ST_DONE,
        ST_ERROR
    } ldr_state_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         WORD_W        = 20;
    localparam int         CK_W          = 16;

    // Each word contributes its low 16 bits plus its top nibble, modulo 2^16.
    function automatic logic [CK_W-1:0] ck_step(input logic [CK_W-1:0] acc,
                                                input logic [WORD_W-1:0] word);
        return acc + word[15:0] + {12'b0, word[19:16]};
    endfunction

endpackage

// File: rtl/j68_ucode_loader.sv
// Boot-time microcode loader: parses a framed byte stream, writes 20-bit words
// to the microcode RAM, reads them back to verify the checksum, then frees the CPU.
module j68_ucode_loader
    import j68_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         ADDR_W    = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_q,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    ldr_state_t r_state;
    ldr_state_t w_next;

    logic              r_s_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [WORD_W-1:0] r_wr_data;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_cap_vld;
    logic              r_cap_last;
    logic              r_done;
    logic              r_error;
    logic              r_cpu_hold;

    logic [7:0]        r_b0;
    logic [7:0]        r_b1;
    logic [7:0]        r_cnt_lo;
    logic [7:0]        r_ck_lo;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_widx;
    logic [CK_W-1:0]   r_wsum;
    logic [CK_W-1:0]   r_rsum;
    logic [CK_W-1:0]   r_rx_ck;

    logic              w_xfer;
    logic [15:0]       w_cnt_full;
    logic              w_cnt_bad;
    logic [WORD_W-1:0] w_word;
    logic              w_nib_bad;
    logic              w_last_word;
    logic [CK_W-1:0]   w_rx_ck;
    logic [CK_W-1:0]   w_rsum_nxt;
    logic              w_rd_last;
    logic              w_accept_nxt;

    assign w_xfer       = s_valid & r_s_ready;
    assign w_cnt_full   = {s_data, r_cnt_lo};
    assign w_cnt_bad    = |(w_cnt_full >> ADDR_W);
    assign w_word       = {s_data[3:0], r_b1, r_b0};
    assign w_nib_bad    = |s_data[7:4];
    assign w_last_word  = (r_widx == r_cnt);
    assign w_rx_ck      = {s_data, r_ck_lo};
    assign w_rsum_nxt   = ck_step(r_rsum, rd_q);
    assign w_rd_last    = r_rd_en && (r_rd_addr == r_cnt);
    assign w_accept_nxt = (w_next != ST_VERIFY) && (w_next != ST_DONE) && (w_next != ST_ERROR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_SYNC:   if (w_xfer && (s_data == SYNC_BYTE)) w_next = ST_CNT_LO;
            ST_CNT_LO: if (w_xfer) w_next = ST_CNT_HI;
            ST_CNT_HI: if (w_xfer) w_next = w_cnt_bad ? ST_ERROR : ST_W0;
            ST_W0:     if (w_xfer) w_next = ST_W1;
            ST_W1:     if (w_xfer) w_next = ST_W2;
            ST_W2: begin
                if (w_xfer) begin
                    if (w_nib_bad)        w_next = ST_ERROR;
                    else if (w_last_word) w_next = ST_CK_LO;
                    else                  w_next = ST_W0;
                end
            end
            ST_CK_LO:  if (w_xfer) w_next = ST_CK_HI;
            ST_CK_HI:  if (w_xfer) w_next = (w_rx_ck != r_wsum) ? ST_ERROR : ST_VERIFY;
            // Decide on the cycle the final readback word is on rd_q.
            ST_VERIFY: if (r_cap_vld && r_cap_last) w_next = (w_rsum_nxt == r_rx_ck) ? ST_DONE : ST_ERROR;
            ST_DONE:   w_next = ST_DONE;
            ST_ERROR:  w_next = ST_ERROR;
            default:   w_next = ST_SYNC;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s_ready  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_last <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cpu_hold <= 1'b1;
        end else begin
            r_s_ready  <= w_accept_nxt;
            r_wr_en    <= (r_state == ST_W2) && w_xfer && !w_nib_bad;
            if ((r_state == ST_W2) && w_xfer && !w_nib_bad) begin
                r_wr_addr <= r_widx;
                r_wr_data <= w_word;
            end
            if ((r_state == ST_CK_HI) && (w_next == ST_VERIFY)) begin
                r_rd_en   <= 1'b1;
                r_rd_addr <= '0;
            end else if (r_rd_en) begin
                if (r_rd_addr == r_cnt) r_rd_en   <= 1'b0;
                else                    r_rd_addr <= r_rd_addr + 1'b1;
            end
            r_cap_vld  <= r_rd_en;
            r_cap_last <= w_rd_last;
            r_done     <= (w_next == ST_DONE);
            r_error    <= (w_next == ST_ERROR);
            r_cpu_hold <= (w_next != ST_DONE);
        end
    end

    // Frame payload registers need no reset: each is loaded before it is used.
    always_ff @(posedge clock) begin
        if (w_xfer) begin
            case (r_state)
                ST_SYNC: begin
                    if (s_data == SYNC_BYTE) begin
                        r_widx <= '0;
                        r_wsum <= '0;
                    end
                end
                ST_CNT_LO: r_cnt_lo <= s_data;
                ST_CNT_HI: r_cnt    <= w_cnt_full[ADDR_W-1:0];
                ST_W0:     r_b0     <= s_data;
                ST_W1:     r_b1     <= s_data;
                ST_W2: begin
                    if (!w_nib_bad) begin
                        r_widx <= r_widx + 1'b1;
                        r_wsum <= ck_step(r_wsum, w_word);
                    end
                end
                ST_CK_LO:  r_ck_lo  <= s_data;
                ST_CK_HI: begin
                    r_rx_ck <= w_rx_ck;
                    r_rsum  <= '0;
                end
                default: ;
            endcase
        end
        if (r_cap_vld) r_rsum <= w_rsum_nxt;
    end

    assign s_ready  = r_s_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign rd_en    = r_rd_en;
    assign rd_addr  = r_rd_addr;
    assign cpu_hold = r_cpu_hold;
    assign done     = r_done;
    assign error    = r_error;

endmodule

// File: tb/tb_j68_ucode_loader.sv
// Self-checking bench for j68_ucode_loader: RAM model, scenario table, frame-level
// reference model and hand-written timing/reset sequences.
module tb_j68_ucode_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [19:0] wr_data;
    logic        rd_en;
    logic [10:0] rd_addr;
    logic [19:0] rd_q;
    logic        cpu_hold;
    logic        done;
    logic        error;

    j68_ucode_loader #(.SYNC_BYTE(8'hA5), .ADDR_W(11)) dut (
        .clock(clock), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_q(rd_q),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM with registered read; optional corruption of bit 19 at address 5.
    logic [19:0] mem [0:2047];
    bit          flip = 1'b0;
    always @(posedge clock) begin
        if (wr_en) mem[wr_addr] <= (flip && wr_addr == 11'd5) ? (wr_data ^ 20'h80000) : wr_data;
        if (rd_en) rd_q <= mem[rd_addr];
    end

    // Observed activity, cleared while reset is asserted.
    logic [10:0] wa_log[$];
    logic [19:0] wd_log[$];
    int nrd = 0, rd_seq_bad = 0, overlap = 0;
    int wr_cyc = -1, last_rd_cyc = -1, done_cyc = -1, hold_cyc = -1;
    always @(negedge clock) begin
        if (!reset) begin
            wa_log.delete();
            wd_log.delete();
            nrd <= 0; rd_seq_bad <= 0; overlap <= 0;
            wr_cyc <= -1; last_rd_cyc <= -1; done_cyc <= -1; hold_cyc <= -1;
        end else begin
            if (wr_en) begin
                wa_log.push_back(wr_addr);
                wd_log.push_back(wr_data);
                wr_cyc <= cyc;
            end
            if (rd_en) begin
                if (rd_addr != nrd[10:0]) rd_seq_bad <= rd_seq_bad + 1;
                nrd <= nrd + 1;
                last_rd_cyc <= cyc;
            end
            if (wr_en && rd_en) overlap <= overlap + 1;
            if (done && done_cyc < 0) done_cyc <= cyc;
            if (!cpu_hold && hold_cyc < 0) hold_cyc <= cyc;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    int xfer_cyc = 0;
    task automatic send_byte(input logic [7:0] b, output bit ok);
        s_valid = 1'b1;
        s_data  = b;
        ok      = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (s_ready) begin
                xfer_cyc = cyc;
                @(posedge clock);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
        end
        if (!ok) s_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        reset   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    logic [7:0] frame[$];

    task automatic build(input int n, input bit garb, input int fault);
        int sum;
        logic [19:0] w;
        logic [7:0]  b2;
        logic [15:0] cnt;
        logic [15:0] ck;
        frame.delete();
        if (garb) begin
            frame.push_back(8'h00); frame.push_back(8'hFF); frame.push_back(8'h5A);
        end
        frame.push_back(8'hA5);
        cnt = 16'(n - 1);
        if (fault == 3) cnt = cnt | 16'h0800;
        frame.push_back(cnt[7:0]);
        frame.push_back(cnt[15:8]);
        sum = 0;
        for (int k = 0; k < n; k++) begin
            w  = 20'($urandom);
            b2 = {4'h0, w[19:16]};
            if (fault == 1 && k == 2) b2 = 8'h1F;
            frame.push_back(w[7:0]);
            frame.push_back(w[15:8]);
            frame.push_back(b2);
            sum = sum + int'(w[15:0]) + int'(w[19:16]);
        end
        ck = 16'(sum);
        if (fault == 2) ck = ck + 16'd1;
        frame.push_back(ck[7:0]);
        frame.push_back(ck[15:8]);
    endtask

    // Reference model: interprets the frame bytes directly.
    int exp_wa[$];
    int exp_wd[$];
    bit exp_done, exp_err;
    int exp_nrd;
    task automatic model(input bit flp);
        int i, cnt, n, sum, rsum, w, ck;
        exp_wa.delete(); exp_wd.delete();
        exp_done = 0; exp_err = 0; exp_nrd = 0;
        i = 0;
        while (i < frame.size() && frame[i] != 8'hA5) i++;
        if (i + 2 >= frame.size()) return;
        cnt = int'(frame[i+1]) + 256 * int'(frame[i+2]);
        i += 3;
        if (cnt > 2047) begin exp_err = 1; return; end
        n = cnt + 1;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            if (frame[i+2] > 8'd15) begin exp_err = 1; return; end
            w = int'(frame[i]) + 256 * int'(frame[i+1]) + 65536 * int'(frame[i+2]);
            exp_wa.push_back(k);
            exp_wd.push_back(w);
            sum = (sum + (w % 65536) + (w / 65536)) % 65536;
            i += 3;
        end
        ck = int'(frame[i]) + 256 * int'(frame[i+1]);
        if (ck != sum) begin exp_err = 1; return; end
        exp_nrd = n;
        rsum = 0;
        for (int k = 0; k < n; k++) begin
            w = exp_wd[k];
            if (flp && k == 5) w = w ^ (1 << 19);
            rsum = (rsum + (w % 65536) + (w / 65536)) % 65536;
        end
        exp_done = (rsum == ck);
        exp_err  = !exp_done;
    endtask

    task automatic send_frame(input bit gaps);
        bit ok;
        for (int i = 0; i < frame.size(); i++) begin
            if (error) break;
            if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send_byte(frame[i], ok);
            if (!ok) break;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        for (int k = 0; k < 6000 && !(done || error); k++) @(posedge clock);
        #1;
        if (!(done || error)) check({nm, "_timeout"}, 0, 1);
        idle(4);
    endtask

    task automatic check_writes(input string nm);
        int bad = 0;
        check({nm, "_nwr"}, wa_log.size(), exp_wa.size());
        for (int k = 0; k < exp_wa.size(); k++)
            if (k >= wa_log.size() || int'(wa_log[k]) != exp_wa[k] || int'(wd_log[k]) != exp_wd[k]) bad++;
        check({nm, "_wr_list"}, bad, 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_s_ready"}, s_ready, 0);
        check({nm, "_wr_en"}, wr_en, 0);
        check({nm, "_wr_addr"}, wr_addr, 0);
        check({nm, "_wr_data"}, wr_data, 0);
        check({nm, "_rd_en"}, rd_en, 0);
        check({nm, "_rd_addr"}, rd_addr, 0);
        check({nm, "_cpu_hold"}, cpu_hold, 1);
        check({nm, "_done"}, done, 0);
        check({nm, "_error"}, error, 0);
    endtask

    typedef struct {
        string nm;
        int    n;
        bit    garb;
        int    fault;
        bit    flp;
        bit    gaps;
        bit    e_done;
        bit    e_err;
    } vec_t;
    vec_t tbl[7];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not end, cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        bit ok;
        int x3;
        tbl[0] = '{"full2048", 2048, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{"garbage",  5,    1'b1, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{"badnib",   3,    1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{"ckoff",    4,    1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{"flip19",   8,    1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{"rand37",   37,   1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{"badcnt",   6,    1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values, then s_ready rising one cycle after release.
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("rst");
        reset = 1'b1;
        #1;
        check("rel_s_ready_0", s_ready, 0);
        @(posedge clock);
        #1;
        check("rel_s_ready_1", s_ready, 1);
        check("rel_cpu_hold", cpu_hold, 1);

        // One-word frame with exact timing checks.
        do_reset();
        flip = 1'b0;
        frame = '{8'hA5, 8'h00, 8'h00, 8'h45, 8'h0C, 8'h00, 8'h45, 8'h0C};
        x3 = 0;
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], ok);
            if (i == 5) x3 = xfer_cyc;
        end
        s_valid = 1'b0;
        wait_end("w1");
        check("w1_nwr", wa_log.size(), 1);
        check("w1_addr", wa_log[0], 0);
        check("w1_data", wd_log[0], 20'h00C45);
        check("w1_wr_cyc", wr_cyc, x3 + 1);
        check("w1_nrd", nrd, 1);
        check("w1_done", done, 1);
        check("w1_error", error, 0);
        check("w1_cpu_hold", cpu_hold, 0);
        check("w1_done_lat", done_cyc, last_rd_cyc + 2);
        check("w1_hold_fall", hold_cyc, done_cyc);
        check("w1_s_ready", s_ready, 0);

        // Scenario table against both its own verdict and the frame model.
        foreach (tbl[t]) begin
            flip = tbl[t].flp;
            do_reset();
            build(tbl[t].n, tbl[t].garb, tbl[t].fault);
            model(tbl[t].flp);
            send_frame(tbl[t].gaps);
            wait_end(tbl[t].nm);
            check({tbl[t].nm, "_done"}, done, tbl[t].e_done);
            check({tbl[t].nm, "_error"}, error, tbl[t].e_err);
            check({tbl[t].nm, "_model_done"}, done, exp_done);
            check({tbl[t].nm, "_cpu_hold"}, cpu_hold, !tbl[t].e_done);
            check({tbl[t].nm, "_s_ready"}, s_ready, 0);
            check_writes(tbl[t].nm);
            check({tbl[t].nm, "_nrd"}, nrd, exp_nrd);
            check({tbl[t].nm, "_rd_seq"}, rd_seq_bad, 0);
            check({tbl[t].nm, "_overlap"}, overlap, 0);
        end
        flip = 1'b0;

        // Reset in the middle of a 100-word load, then a clean reload.
        do_reset();
        build(100, 1'b0, 0);
        for (int i = 0; i < 33; i++) send_byte(frame[i], ok);
        idle(2);
        check("mid_nwr", wa_log.size(), 10);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        idle(2);
        reset = 1'b1;
        build(100, 1'b0, 0);
        model(1'b0);
        send_frame(1'b1);
        wait_end("reload");
        check("reload_done", done, 1);
        check("reload_error", error, 0);
        check_writes("reload");
        check("reload_nrd", nrd, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
